enc16x4_seq: RTL and testbench
==============================

ENC16X4_SEQ -- requirements
Module: enc16x4_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (16-bit request vector, 4-bit code).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  capture request: sample Y when the block is idle.
REQ-005 Y  input  16  active-low request vector, same polarity as 4x16 decoder output (bit i = 0 means index i requested).
REQ-006 ready  input  1  downstream accepts the current code.
REQ-007 A  output  4  encoded index of the current request.
REQ-008 valid  output  1  A holds a valid code.
REQ-009 busy  output  1  high from capture until the done pulse, inclusive.
REQ-010 done  output  1  one-cycle pulse at end of each job.
REQ-011 none  output  1  one-cycle pulse, coincident with done, when the captured Y had no low bits.
REQ-012 count  output  5  number of codes accepted in the current/last job (0..16).

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, FIN; encoding is free.
REQ-014 In IDLE with start=1, the block SHALL register pending = ~Y, clear count to 0, and set busy=1 on the next edge.
REQ-015 If ~Y == 0 at capture, the block SHALL go to FIN with valid=0; otherwise it SHALL go to SCAN with valid=1 and A = lowest index i where Y[i]=0; latency start->valid = 1 cycle.
REQ-016 In SCAN, a handshake occurs on an edge with valid=1 and ready=1; at most one code is transferred per cycle.
REQ-017 On a handshake, the block SHALL clear the lowest set pending bit (pending & (pending-1)), increment count, and load A with the lowest index of the new pending value.
REQ-018 Codes SHALL be emitted in strictly ascending index order, each requested index exactly once.
REQ-019 While valid=1 and ready=0, A, valid, and count SHALL hold unchanged.
REQ-020 The handshake that empties pending SHALL drop valid on the same edge and move the FSM to FIN.
REQ-021 FIN SHALL last exactly one cycle: done=1, none=1 iff count==0, busy=1; the next edge returns the FSM to IDLE with busy=0 and done=0.
REQ-022 start SHALL be ignored in SCAN and FIN; Y SHALL be ignored except at capture.
REQ-023 A SHALL read 0 whenever valid=0 and the FSM is idle; count SHALL hold its final value in IDLE until the next capture.
REQ-024 count SHALL saturate naturally at 16 (all 16 requested); no wrap-around is possible.
REQ-025 A back-to-back job SHALL be possible: start in the first IDLE cycle after FIN captures immediately.

Reset
REQ-026 rst_n=0 SHALL, without waiting for clk, force FSM=IDLE, pending=0, A=0, valid=0, busy=0, done=0, none=0, count=0.
REQ-027 Reset asserted mid-SCAN SHALL abandon the job; no done pulse SHALL follow deassertion.
REQ-028 After rst_n rises, the first start on a clock edge SHALL be accepted normally.

Verification
REQ-029 Y=16'hFFFE, start 1 cycle, ready=1 -> next cycle valid=1 A=0; then done=1 none=0 count=1; busy low after.
REQ-030 Y=16'h7FFE, ready=1 -> A=0 then A=15 in consecutive cycles; count=2; done single pulse.
REQ-031 Y=16'hFFFF -> valid never asserted; FIN cycle done=1 none=1 count=0.
REQ-032 Y=16'h0000, ready toggling 1/0 -> A=0..15 ascending, A held whenever ready=0; count=16; done after 16th handshake.
REQ-033 Start with Y=16'hFFF0, then assert start with Y=16'h0000 during SCAN -> second start ignored; exactly codes 0,1,2,3 emitted.
REQ-034 rst_n low asynchronously after 2nd handshake of Y=16'h0000 -> all outputs 0 immediately; no done pulse; new start with Y=16'hFFFD -> A=1 count=1.

Source files
------------

// File: rtl/enc16x4_seq.sv
// enc16x4_seq: captures an active-low 16-bit request vector and emits the requested
// indices one by one, in ascending order, over a valid/ready handshake.
module enc16x4_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] Y,
    input  logic        ready,
    output logic [3:0]  A,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        none,
    output logic [4:0]  count
);
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t      state;
    logic [15:0] pending;
    logic [15:0] req;
    logic [15:0] nxt;

    function automatic logic [3:0] lowest(input logic [15:0] p);
        lowest = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (p[i]) lowest = 4'(i);
    endfunction

    always_comb begin
        req = ~Y;
        nxt = pending & (pending - 16'd1);
    end

    // lowest(0) is 0, so A returns to 0 on its own when the last code is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 16'd0;
            A       <= 4'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            none    <= 1'b0;
            count   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    none <= 1'b0;
                    if (start) begin
                        pending <= req;
                        count   <= 5'd0;
                        busy    <= 1'b1;
                        if (req == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            none  <= 1'b1;
                        end else begin
                            state <= SCAN;
                            valid <= 1'b1;
                            A     <= lowest(req);
                        end
                    end
                end
                SCAN: begin
                    if (ready) begin
                        pending <= nxt;
                        count   <= count + 5'd1;
                        A       <= lowest(nxt);
                        if (nxt == 16'd0) begin
                            valid <= 1'b0;
                            done  <= 1'b1;
                            none  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    none  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc16x4_seq.sv
// tb_enc16x4_seq: directed scenario tests for enc16x4_seq.
module tb_enc16x4_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] Y = 16'hFFFF;
    logic        ready = 1'b0;
    logic [3:0]  A;
    logic        valid, busy, done, none;
    logic [4:0]  count;
    logic [12:0] obs, exp;
    int          total = 0;
    int          bad = 0;

    enc16x4_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Y(Y), .ready(ready),
        .A(A), .valid(valid), .busy(busy), .done(done), .none(none), .count(count)
    );

    always #5 clk = ~clk;
    // observed word: {valid, busy, done, none, count, A}
    assign obs = {valid, busy, done, none, count, A};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        exp = 13'd0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, exp); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        Y = 16'hFFFE; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_valid got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_done got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_idle got=%h want=%h", obs, exp); end
    endtask

    task automatic test_two();
        Y = 16'h7FFE; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL two_first got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 4'd15};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL two_second got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL two_done got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL two_idle got=%h want=%h", obs, exp); end
    endtask

    task automatic test_empty();
        Y = 16'hFFFF; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL empty_fin got=%h want=%h", obs, exp); end
        tick();
        exp = 13'd0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL empty_idle got=%h want=%h", obs, exp); end
    endtask

    task automatic test_all_toggle();
        Y = 16'h0000; start = 1'b1; ready = 1'b0;
        tick();
        start = 1'b0;
        Y = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            ready = 1'b0;
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'(i), 4'(i)};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL all_code%0d got=%h want=%h", i, obs, exp); end
            tick();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL all_hold%0d got=%h want=%h", i, obs, exp); end
            ready = 1'b1;
            tick();
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL all_done got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL all_idle got=%h want=%h", obs, exp); end
    endtask

    task automatic test_ignore_start();
        Y = 16'hFFF0; start = 1'b1; ready = 1'b1;
        tick();
        Y = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'(i), 4'(i)};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL ign_code%0d got=%h want=%h", i, obs, exp); end
            tick();
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL ign_done got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL ign_fin_start got=%h want=%h", obs, exp); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        Y = 16'hFFFE; start = 1'b1; ready = 1'b1;
        tick();
        Y = 16'hFFFB;
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_done got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_idle got=%h want=%h", obs, exp); end
        tick();
        start = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'd2};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_capture got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b2b_done2 got=%h want=%h", obs, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        Y = 16'h0000; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 4'd2};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_pre got=%h want=%h", obs, exp); end
        #2;
        rst_n = 1'b0;
        #1;
        exp = 13'd0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_async got=%h want=%h", obs, exp); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL rmid_quiet%0d got=%h want=%h", i, obs, exp); end
        end
        Y = 16'hFFFD; start = 1'b1;
        tick();
        start = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 4'd1};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_restart got=%h want=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 4'd0};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rmid_done got=%h want=%h", obs, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_empty();
        test_all_toggle();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
